// File: rtl/per_gen.sv
// rtl/per_gen.sv - programmable period generator with double-buffered reload
// Optional square-wave output enabled by defining PER_GEN_SQ_EN.
module per_gen #(
  parameter int               WIDTH      = 9,
  parameter logic [WIDTH-1:0] RST_PERIOD = 9'd100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             per_ld,
  input  logic [WIDTH-1:0] per_in,
  output logic             pulse,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] per_active,
  output logic             per_pend,
  output logic             sq
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_per_active, w_per_active_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic             r_per_pend, w_per_pend_nxt;
  logic             w_boundary;
  logic [WIDTH-1:0] w_p_bnd;

  assign w_boundary = (r_state == RUN) && (r_cnt == '0);
  // A load arriving on the boundary cycle itself outranks the shadow.
  assign w_p_bnd    = per_ld ? per_in : (r_per_pend ? r_shadow : r_per_active);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_per_active_nxt = r_per_active;
    w_shadow_nxt     = r_shadow;
    w_per_pend_nxt   = r_per_pend;

    if (per_ld) begin
      w_shadow_nxt   = per_in;
      w_per_pend_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (r_per_pend) begin
          w_per_active_nxt = r_shadow;
          if (!per_ld) w_per_pend_nxt = 1'b0;
        end
        if (en && (r_per_active != '0)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = r_per_active - WIDTH'(1);
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end else begin
          w_per_active_nxt = w_p_bnd;
          w_shadow_nxt     = r_shadow;
          w_per_pend_nxt   = 1'b0;
          if (w_p_bnd == '0) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_p_bnd - WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_per_active <= RST_PERIOD;
      r_shadow     <= '0;
      r_per_pend   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_per_active <= w_per_active_nxt;
      r_shadow     <= w_shadow_nxt;
      r_per_pend   <= w_per_pend_nxt;
    end
  end

`ifdef PER_GEN_SQ_EN
  logic r_sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sq <= 1'b0;
    end else if (w_state_nxt == IDLE) begin
      r_sq <= 1'b0;
    end else if (w_boundary) begin
      r_sq <= ~r_sq;
    end
  end

  assign sq = r_sq;
`else
  assign sq = 1'b0;
`endif

  assign pulse      = w_boundary;
  assign cnt        = r_cnt;
  assign per_active = r_per_active;
  assign per_pend   = r_per_pend;

endmodule
